// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: forward-select
// codes, FSM encoding and the bundled pipeline-register control word.
package hazard_ctrl_pkg;

  localparam int REG_IDX_BIT = 5;
  localparam int FWD_SEL_BIT = 2;

  localparam logic [FWD_SEL_BIT-1:0] FWD_RF  = 2'd0;
  localparam logic [FWD_SEL_BIT-1:0] FWD_MEM = 2'd1;
  localparam logic [FWD_SEL_BIT-1:0] FWD_WB  = 2'd2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic ps1_en;
    logic ps1_clear;
    logic ps2_en;
    logic ps2_clear;
    logic ps3_en;
    logic ps3_clear;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, ps1_en: 1'b1, ps1_clear: 1'b0, ps2_en: 1'b1,
    ps2_clear: 1'b0, ps3_en: 1'b1, ps3_clear: 1'b0
  };

  localparam pipe_ctrl_t CTRL_FREEZE = '{
    pc_en: 1'b0, ps1_en: 1'b0, ps1_clear: 1'b0, ps2_en: 1'b0,
    ps2_clear: 1'b0, ps3_en: 1'b0, ps3_clear: 1'b0
  };

  // MEM has the younger result, so it wins over WB; r0 is hardwired zero.
  function automatic logic [FWD_SEL_BIT-1:0] fwd_sel(
    input logic [REG_IDX_BIT-1:0] src,
    input logic                   mem_w_en,
    input logic [REG_IDX_BIT-1:0] mem_req_w,
    input logic                   wb_w_en,
    input logic [REG_IDX_BIT-1:0] wb_req_w
  );
    logic [FWD_SEL_BIT-1:0] sel;
    sel = FWD_RF;
    if (mem_w_en && (mem_req_w != '0) && (mem_req_w == src)) begin
      sel = FWD_MEM;
    end else if (wb_w_en && (wb_req_w != '0) && (wb_req_w == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous level.
// rise_o pulses for one cycle, two edges after the input settles high.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control: load-use stall, mispredict flush, syscall halt/resume, EX forwarding.
// Enables/clears/forwarding are combinational (act on the same edge); no backpressure.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_BIT = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_IDX_BIT-1:0] id_req_a,
  input  logic [REG_IDX_BIT-1:0] id_req_b,
  input  logic                   id_use_a,
  input  logic                   id_use_b,
  input  logic [REG_IDX_BIT-1:0] ex_req_a,
  input  logic [REG_IDX_BIT-1:0] ex_req_b,
  input  logic [REG_IDX_BIT-1:0] ex_req_w,
  input  logic                   ex_w_en,
  input  logic                   ex_r_datamem,
  input  logic [REG_IDX_BIT-1:0] mem_req_w,
  input  logic                   mem_w_en,
  input  logic [REG_IDX_BIT-1:0] wb_req_w,
  input  logic                   wb_w_en,
  input  logic                   ex_mispredict,
  input  logic                   ex_halt,
  input  logic                   resume,
  output logic                   pc_en,
  output logic                   ps1_en,
  output logic                   ps1_clear,
  output logic                   ps2_en,
  output logic                   ps2_clear,
  output logic                   ps3_en,
  output logic                   ps3_clear,
  output logic [FWD_SEL_BIT-1:0] fwd_a,
  output logic [FWD_SEL_BIT-1:0] fwd_b,
  output logic                   halted,
  output logic [CNT_BIT-1:0]     stall_cnt,
  output logic [CNT_BIT-1:0]     flush_cnt
);

  localparam logic [CNT_BIT-1:0] CNT_ONE = {{(CNT_BIT-1){1'b0}}, 1'b1};
  localparam logic [CNT_BIT-1:0] CNT_MAX = {CNT_BIT{1'b1}};

  hz_state_e          state_q, state_d;
  logic [CNT_BIT-1:0] stall_q, stall_d;
  logic [CNT_BIT-1:0] flush_q, flush_d;
  pipe_ctrl_t         ctrl;
  logic               stall_evt;
  logic               flush_evt;
  logic               resume_rise;
  logic               lu;
  logic               hit_a;
  logic               hit_b;

  sync_edge u_resume_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (resume),
    .rise_o  (resume_rise)
  );

  assign hit_a = id_use_a && (id_req_a == ex_req_w);
  assign hit_b = id_use_b && (id_req_b == ex_req_w);
  assign lu    = ex_r_datamem && ex_w_en && (ex_req_w != '0) && (hit_a || hit_b);

  // Outputs are held at run/no-hazard values while reset is asserted.
  always_comb begin
    state_d   = state_q;
    ctrl      = CTRL_RUN;
    stall_evt = 1'b0;
    flush_evt = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_RUN: begin
          if (ex_halt) begin
            state_d        = ST_HALT;
            ctrl.pc_en     = 1'b0;
            ctrl.ps1_en    = 1'b0;
            ctrl.ps2_clear = 1'b1;
          end else if (ex_mispredict) begin
            ctrl.ps1_clear = 1'b1;
            ctrl.ps2_clear = 1'b1;
            flush_evt      = 1'b1;
          end else if (lu) begin
            ctrl.pc_en     = 1'b0;
            ctrl.ps1_en    = 1'b0;
            ctrl.ps2_clear = 1'b1;
            stall_evt      = 1'b1;
          end
        end
        ST_HALT: begin
          ctrl      = CTRL_FREEZE;
          stall_evt = 1'b1;
          if (resume_rise) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_evt && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end
    if (flush_evt && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign pc_en     = ctrl.pc_en;
  assign ps1_en    = ctrl.ps1_en;
  assign ps1_clear = ctrl.ps1_clear;
  assign ps2_en    = ctrl.ps2_en;
  assign ps2_clear = ctrl.ps2_clear;
  assign ps3_en    = ctrl.ps3_en;
  assign ps3_clear = ctrl.ps3_clear;

  assign fwd_a = rst_n ? fwd_sel(ex_req_a, mem_w_en, mem_req_w, wb_w_en, wb_req_w) : FWD_RF;
  assign fwd_b = rst_n ? fwd_sel(ex_req_b, mem_w_en, mem_req_w, wb_w_en, wb_req_w) : FWD_RF;

  assign halted    = (state_q == ST_HALT);
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control block for the five-stage core: it drives the `en`/`clear` inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC enable, and selects EX-stage operand forwarding. It consumes the hazard-relevant fields those registers emit, including `regfile_req_w`, `regfile_w_en`, `r_datamem` and `syscall_en`. It detects load-use hazards, flushes on branch mispredict and freezes the pipe on a halting syscall until an external resume. It keeps saturating stall and flush counters for the debug display.

## Interface
- `CNT_BIT`, 32, width of the stall and flush counters.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_req_a`, `id_req_b` in 5 each: source register numbers decoded in ID.
- `id_use_a`, `id_use_b` in 1 each: the ID instruction reads that source.
- `ex_req_a`, `ex_req_b` in 5 each: source registers of the instruction in EX.
- `ex_req_w` in 5, `ex_w_en` in 1, `ex_r_datamem` in 1: destination, write enable and load flag of the instruction in EX.
- `mem_req_w` in 5, `mem_w_en` in 1: destination and write enable in MEM.
- `wb_req_w` in 5, `wb_w_en` in 1: destination and write enable in WB.
- `ex_mispredict` in 1: EX resolved target differs from `pc_guessed`.
- `ex_halt` in 1: halting syscall in EX.
- `resume` in 1: asynchronous push-button, active-high.
- `pc_en` out 1: PC update enable.
- `ps1_en`, `ps1_clear` out 1 each: IF/ID register control.
- `ps2_en`, `ps2_clear` out 1 each: ID/EX register control.
- `ps3_en`, `ps3_clear` out 1 each: EX/MEM register control.
- `fwd_a`, `fwd_b` out 2 each: EX operand select. 0 = regfile, 1 = MEM result, 2 = WB result.
- `halted` out 1: the FSM is in HALT.
- `stall_cnt`, `flush_cnt` out `CNT_BIT` each: event counters.

## Operation
- FSM states: RUN, HALT. Reset state is RUN.
- **Load-use hazard (`lu`)**: asserted when `ex_r_datamem && ex_w_en && ex_req_w != 0` and (`id_use_a && id_req_a == ex_req_w` or `id_use_b && id_req_b == ex_req_w`).
- **RUN priority, highest first:**
  - **`ex_halt`**: next state is HALT. In this cycle `ps3_en=1` so the syscall advances. `pc_en=0`, `ps1_en=0`, `ps2_clear=1`.
  - **`ex_mispredict`**: `ps1_clear=1`, `ps2_clear=1`, `pc_en=1` (PC loads the redirect). `flush_cnt` increments.
  - **`lu`**: `pc_en=0`, `ps1_en=0`, `ps2_clear=1` (one bubble). `stall_cnt` increments.
  - **No hazard**: all enables 1, all clears 0.
- **HALT:**
  - All `*_en=0`, all clears 0, `halted=1`. `stall_cnt` increments every cycle.
  - On a synchronized rising edge of `resume`, return to RUN; the next cycle is normal.
- **`resume` synchronizer**: two flops, then an edge-detect flop, all reset to 0. A held button yields exactly one resume.
- **Forwarding** (combinational, per operand; shown for `fwd_a`):
  - 1 if `mem_w_en && mem_req_w != 0 && mem_req_w == ex_req_a`;
  - else 2 if the same condition holds for WB;
  - else 0.
  - MEM beats WB. Register 0 is never forwarded.
- **Counters**: saturate at all-ones and never wrap.
- **Reset values**: state RUN; counters 0; `halted=0`; synchronizer flops 0. All other outputs are combinational and show RUN/no-hazard values during reset (enables 1, clears 0, `fwd`=0).

## Timing
- `lu`, mispredict, forwarding and all `en`/`clear` outputs are combinational from the inputs and the current state, and act on the same clock edge.
- The load-use bubble lasts exactly one cycle. After the bubble, the load is in MEM, `lu` deasserts and forwarding from MEM resolves the operand.
- HALT is entered on the edge after `ex_halt` is sampled.
- Resume latency is 3 clk edges from a stable `resume` high to the state returning to RUN.
- Mispredict during HALT is ignored, because EX is frozen.
- `ex_halt` together with `ex_mispredict`: halt wins. The syscall is not a branch, so this combination only arises from a bad stimulus.
- Reset asserted mid-stall or mid-HALT returns to RUN immediately and clears the counters.

## Structure
- Add `FWD_SEL_BIT` and the values `FWD_RF`, `FWD_MEM`, `FWD_WB` to `Core.vh`.
- Add the FSM state encodings to `Core.vh`, beside `MUX_ALU_DATAY_BIT`.
- One sub-module, `sync_edge`: the 2-flop synchronizer plus rising-edge detector for `resume`.

## Test plan
- `ex_r_datamem=1`, `ex_w_en=1`, `ex_req_w=8`, `id_use_a=1`, `id_req_a=8` → one cycle with `pc_en=0`, `ps1_en=0`, `ps2_clear=1`; `stall_cnt` goes 0→1. Same stimulus with `ex_req_w=0` → no stall.
- `ex_mispredict=1` together with `lu=1` → `ps1_clear=1`, `ps2_clear=1`, `pc_en=1`; `flush_cnt=1`, `stall_cnt` unchanged.
- `mem_w_en=1`, `mem_req_w=5`, `wb_w_en=1`, `wb_req_w=5`, `ex_req_b=5` → `fwd_b=1`. Clear `mem_w_en` → `fwd_b=2`.
- `ex_halt` pulse → `halted=1` on the next edge with all enables 0. Hold `resume` high for 10 cycles → exactly one return to RUN, 3 edges after `resume` rises.
- Preload `stall_cnt` near all-ones via `CNT_BIT=4`, then apply 20 stall cycles → the counter holds at 15.
- Assert `rst_n=0` while in HALT → `halted=0` and counters 0 immediately; the RUN outputs hold after release.
